// File: rtl/line_clear.sv
`default_nettype none
// ============================================================================
//  Module   : line_clear
//  Purpose  : Post-lock row compaction for the playfield. A merged board is
//             captured on start, scanned bottom-to-top one row per clock,
//             full rows are dropped and the survivors are packed downward.
//             Cleared rows reappear as empty rows at the top of the board.
//  Ports    : clk          - system clock, rising edge
//             clr          - synchronous active-low clear
//             start        - one-cycle request, honoured only when idle
//             board_in     - merged board, bit = row*COL + col, row 0 on top
//             board_out    - compacted board, same layout as board_in
//             busy         - a pass is in progress
//             done         - one-cycle pulse, board_out/lines valid from here
//             lines        - rows cleared by the last pass
//             score        - accumulated score, saturating at 16'hFFFF
//             total_lines  - accumulated cleared rows, saturating at 1023
//  Options  : LINE_CLEAR_SCORE_EN - when defined, score and total_lines
//             accumulate; otherwise both are tied to zero and no
//             accumulator registers exist.
//  Revision : 1.0 - initial release
// ============================================================================
module line_clear #(
    parameter int ROW = 20,
    parameter int COL = 10
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [ROW*COL-1:0]   board_in,
    output logic [ROW*COL-1:0]   board_out,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines,
    output logic [15:0]          score,
    output logic [9:0]           total_lines
);

    localparam int c_IW = (ROW > 1) ? $clog2(ROW) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;

    logic [ROW*COL-1:0] r_src;
    logic [ROW*COL-1:0] r_dst;
    logic [ROW*COL-1:0] r_board_out;
    logic [ROW*COL-1:0] w_dst_next;
    logic [c_IW-1:0]    r_rd;
    logic [c_IW-1:0]    r_wr;
    logic [4:0]         r_cnt;
    logic [4:0]         w_cnt_next;
    logic [4:0]         r_lines;
    logic               r_done;

    logic [COL-1:0]     w_row;
    logic               w_full;
    logic               w_last;
    logic               w_finish;

    // Row under test and the dst/cnt values it produces. The final row's
    // result is folded in here so board_out can be loaded with it directly.
    always_comb begin
        w_row      = r_src[r_rd*COL +: COL];
        w_full     = &w_row;
        w_last     = (r_rd == '0);
        w_dst_next = r_dst;
        if (!w_full) begin
            w_dst_next[r_wr*COL +: COL] = w_row;
        end
        w_cnt_next = r_cnt + {4'd0, w_full};
    end

    assign w_finish = (r_state == S_SCAN) && w_last;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_SCAN;
            S_SCAN:  if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Scan datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_cnt       <= '0;
            r_board_out <= '0;
            r_lines     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src <= board_in;
                        r_dst <= '0;
                        r_rd  <= c_IW'(ROW - 1);
                        r_wr  <= c_IW'(ROW - 1);
                        r_cnt <= '0;
                    end
                end
                S_SCAN: begin
                    r_dst <= w_dst_next;
                    r_cnt <= w_cnt_next;
                    if (!w_last) begin
                        r_rd <= r_rd - 1'b1;
                    end
                    // Stop at row 0: with no full rows the write pointer
                    // lands exactly there on the final row.
                    if (!w_full && (r_wr != '0)) begin
                        r_wr <= r_wr - 1'b1;
                    end
                    if (w_last) begin
                        r_board_out <= w_dst_next;
                        r_lines     <= w_cnt_next;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign board_out = r_board_out;
    assign lines     = r_lines;
    assign done      = r_done;
    assign busy      = (r_state == S_SCAN);

    // ------------------------------------------------------------------
    // Score / line accumulators
    // ------------------------------------------------------------------
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] r_score;
    logic [9:0]  r_total;
    logic [15:0] w_inc;
    logic [16:0] w_score_sum;
    logic [10:0] w_total_sum;

    always_comb begin
        case (w_cnt_next)
            5'd0:    w_inc = 16'd0;
            5'd1:    w_inc = 16'd40;
            5'd2:    w_inc = 16'd100;
            5'd3:    w_inc = 16'd300;
            default: w_inc = 16'd1200;
        endcase
        w_score_sum = {1'b0, r_score} + {1'b0, w_inc};
        w_total_sum = {1'b0, r_total} + {6'd0, w_cnt_next};
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_score <= '0;
            r_total <= '0;
        end else if (w_finish) begin
            r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
            r_total <= w_total_sum[10] ? 10'd1023 : w_total_sum[9:0];
        end
    end

    assign score       = r_score;
    assign total_lines = r_total;
`else
    logic w_unused;
    assign w_unused    = w_finish;
    assign score       = 16'd0;
    assign total_lines = 10'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_clear.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_clear
//  Purpose  : Directed self-checking bench for line_clear. Expected values
//             are hand-computed boards and totals; score expectations
//             follow LINE_CLEAR_SCORE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_clear;

    localparam int ROW = 20;
    localparam int COL = 10;
    localparam int N   = ROW * COL;

`ifdef LINE_CLEAR_SCORE_EN
    localparam bit c_SCORE_EN = 1'b1;
`else
    localparam bit c_SCORE_EN = 1'b0;
`endif

    logic         clk;
    logic         clr;
    logic         start;
    logic [N-1:0] board_in;
    logic [N-1:0] board_out;
    logic         busy;
    logic         done;
    logic [4:0]   lines;
    logic [15:0]  score;
    logic [9:0]   total_lines;

    int n_vec;
    int n_err;

    line_clear #(.ROW(ROW), .COL(COL)) u_dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .board_in    (board_in),
        .board_out   (board_out),
        .busy        (busy),
        .done        (done),
        .lines       (lines),
        .score       (score),
        .total_lines (total_lines)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] set_row(input logic [N-1:0] b, input int r, input logic [COL-1:0] v);
        logic [N-1:0] t;
        t = b;
        t[r*COL +: COL] = v;
        return t;
    endfunction

    function automatic logic [15:0] exp_sc(input int v);
        return c_SCORE_EN ? 16'(v) : 16'd0;
    endfunction

    // Pulse start with board b and wait for done; edges counts clock edges
    // from the start edge inclusive up to the edge that raised done.
    task automatic run_pass(input logic [N-1:0] b, output int edges);
        board_in = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        board_in = '1;          // must be ignored during the scan
        edges    = 1;
        while (!done && edges < ROW + 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
    endtask

    logic [N-1:0] b1, e1, b2, e2, b4, e4, bfull;
    int edges;
    int nd;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        clr      = 1'b0;
        start    = 1'b1;
        board_in = '1;

        // Full bottom row plus one stray bit just above it.
        b1 = '0;
        b1 = set_row(b1, 19, 10'h3FF);
        b1[18*COL + 3] = 1'b1;
        e1 = '0;
        e1[19*COL + 3] = 1'b1;

        // Four interleaved full rows.
        b2 = '0;
        b2 = set_row(b2, 19, 10'h3FF);
        b2 = set_row(b2, 18, 10'h001);
        b2 = set_row(b2, 17, 10'h3FF);
        b2 = set_row(b2, 16, 10'h200);
        b2 = set_row(b2, 15, 10'h3FF);
        b2 = set_row(b2, 13, 10'h3FF);
        e2 = '0;
        e2 = set_row(e2, 19, 10'h001);
        e2 = set_row(e2, 18, 10'h200);

        // Only the top row full: everything else keeps its place.
        b4 = '0;
        b4 = set_row(b4, 0,  10'h3FF);
        b4 = set_row(b4, 1,  10'h155);
        b4 = set_row(b4, 10, 10'h0F0);
        b4 = set_row(b4, 19, 10'h2AA);
        e4 = set_row(b4, 0,  10'h000);

        bfull = '1;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        clr   = 1'b1;
        start = 1'b0;
        board_in = '0;
        @(posedge clk); #1;
        check("rst_board", board_out, '0);
        check("rst_busy",  N'(busy), '0);
        check("rst_done",  N'(done), '0);
        check("rst_lines", N'(lines), '0);
        check("rst_score", N'(score), '0);
        check("rst_total", N'(total_lines), '0);

        // ---------------- single bottom row ----------------
        run_pass(b1, edges);
        check("t1_latency", N'(edges), N'(ROW + 1));
        check("t1_board",   board_out, e1);
        check("t1_lines",   N'(lines), N'(1));
        check("t1_score",   N'(score), N'(exp_sc(40)));
        check("t1_total",   N'(total_lines), N'(exp_sc(1)));
        @(posedge clk); #1;
        check("t1_done_pulse", N'(done), '0);
        check("t1_hold", board_out, e1);

        // ---------------- four rows ----------------
        run_pass(b2, edges);
        check("t2_done",  N'(done), N'(1));
        check("t2_board", board_out, e2);
        check("t2_lines", N'(lines), N'(4));
        check("t2_score", N'(score), N'(exp_sc(1240)));
        check("t2_total", N'(total_lines), N'(exp_sc(5)));

        // ---------------- empty board ----------------
        run_pass('0, edges);
        check("t3_done",  N'(done), N'(1));
        check("t3_board", board_out, '0);
        check("t3_lines", N'(lines), '0);
        check("t3_score", N'(score), N'(exp_sc(1240)));
        count_done(5, nd);
        check("t3_one_done", N'(nd), '0);

        // ---------------- top row only ----------------
        run_pass(b4, edges);
        check("t4_board", board_out, e4);
        check("t4_lines", N'(lines), N'(1));
        check("t4_score", N'(score), N'(exp_sc(1280)));

        // ---------------- every row full ----------------
        run_pass(bfull, edges);
        check("t5_board", board_out, '0);
        check("t5_lines", N'(lines), N'(ROW));
        check("t5_score", N'(score), N'(exp_sc(2480)));
        check("t5_total", N'(total_lines), N'(exp_sc(26)));

        // ---------------- start while busy is ignored ----------------
        board_in = b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_busy", N'(busy), N'(1));
        board_in = bfull;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        count_done(ROW + 20, nd);
        check("t6_ndone", N'(nd), N'(1));
        check("t6_board", board_out, e1);
        check("t6_lines", N'(lines), N'(1));
        check("t6_score", N'(score), N'(exp_sc(2520)));

        // ---------------- clear mid-pass ----------------
        board_in = b2;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        count_done(ROW + 10, nd);
        check("t7_ndone", N'(nd), '0);
        check("t7_busy",  N'(busy), '0);
        check("t7_board", board_out, '0);
        check("t7_lines", N'(lines), '0);
        check("t7_score", N'(score), '0);
        check("t7_total", N'(total_lines), '0);

        // ---------------- re-entry after clear ----------------
        run_pass(b2, edges);
        check("t8_latency", N'(edges), N'(ROW + 1));
        check("t8_board",   board_out, e2);
        check("t8_lines",   N'(lines), N'(4));
        check("t8_score",   N'(score), N'(exp_sc(1200)));
        check("t8_total",   N'(total_lines), N'(exp_sc(4)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_clear.md
# line_clear

Post-lock row-compaction stage for the Tetris playfield. Sits directly downstream of the piece/board merge stage. When the active piece locks, the merged visible board is loaded here. The block then scans it bottom-to-top, deletes every full row, and shifts the remaining rows down. It returns the compacted board, plus the number of rows cleared and the running score and line totals.

## Interface
Parameters:
- ROW, 20, number of visible board rows.
- COL, 10, number of board columns.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- clr  input  1  synchronous, active-low clear (low at a rising clk edge resets the block).
- start  input  1  one-cycle request to process board_in; sampled only in IDLE.
- board_in  input  ROW*COL  merged board; bit index = row*COL + col, row 0 = top, row ROW-1 = bottom.
- board_out  output  ROW*COL  compacted board, same bit layout as board_in.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse; board_out and lines are valid from this cycle onward.
- lines  output  5  rows cleared by the last pass, 0..ROW.
- score  output  16  accumulated score, saturating.
- total_lines  output  10  accumulated cleared rows, saturating.

## Operation
State machine: IDLE, SCAN.

IDLE:
- busy = 0.
- On start = 1, the block:
  - captures board_in into src;
  - clears dst to 0;
  - sets rd = ROW-1, wr = ROW-1, cnt = 0;
  - moves to SCAN.
- start = 0 holds IDLE; all outputs hold.

SCAN, one row per cycle:
- The row under test is src[rd*COL +: COL]. It is full when all COL bits are 1.
- Full row: cnt <= cnt+1; wr is unchanged.
- Non-full row: dst[wr*COL +: COL] <= the row; wr <= wr-1.
- rd <= rd-1 after each row.
- Rows of dst above the final wr stay 0, so cleared rows appear as empty rows at the top.
- After row 0 is processed:
  - board_out <= final dst, including the row-0 result;
  - lines <= final cnt;
  - done <= 1;
  - accumulators update;
  - the state returns to IDLE.

Score increment, added once per pass:
- cnt = 0: +0.
- cnt = 1: +40.
- cnt = 2: +100.
- cnt = 3: +300.
- cnt >= 4: +1200.

Arithmetic rules:
- score saturates at 16'hFFFF.
- total_lines += cnt and saturates at 1023.
- rd, wr and cnt are wide enough that they never wrap within a pass.
- wr is not decremented below 0. If no row is full, wr reaches 0 at the last row, which is correct.

## Timing
- Reset values (clr low at a rising edge):
  - board_out = 0, busy = 0, done = 0, lines = 0, score = 0, total_lines = 0;
  - state = IDLE.
- clr has priority over all other inputs.
- Clear mid-pass: the pass is aborted and no done is produced.
- Latency: start sampled at edge E0.
  - busy is high from after E0 until after E_ROW.
  - Rows ROW-1..0 are processed on edges E1..E_ROW.
  - done is high for exactly the cycle following E_ROW.
  - Total: ROW+1 edges from start to done.
- start while busy = 1 is ignored; it is not queued.
- start in the same cycle as done = 1 is accepted, because the state is already IDLE.
- board_in is only sampled at E0; changes during SCAN have no effect.
- Between passes, board_out, lines and done = 0 hold their values.

## Configuration
- LINE_CLEAR_SCORE_EN defined:
  - score and total_lines accumulate as described above.
- LINE_CLEAR_SCORE_EN undefined:
  - score and total_lines are constant 0 and no accumulator registers are built;
  - board_out, lines, busy and done are unaffected.

## Test plan
- Reset: hold clr = 0 for 2 cycles with arbitrary inputs, then release -> all outputs 0, busy = 0.
- Single full bottom row, otherwise board_in has only bit 18*COL+3 set; pulse start:
  - done arrives exactly ROW+1 edges after the start edge;
  - board_out has only bit 19*COL+3 set;
  - lines = 1, score = 40, total_lines = 1.
- Rows 19, 17, 15 and 13 full, row 18 = 10'h001, row 16 = 10'h200, everything else 0:
  - lines = 4;
  - board_out row 19 = 10'h001, row 18 = 10'h200, all other rows 0;
  - score increases by 1200.
- Empty board_in: lines = 0, board_out = 0, score unchanged, done still pulses once.
- Abort and re-entry:
  - pulse start again at cycle 5 of a pass -> ignored, only one done;
  - drive clr = 0 mid-pass -> no done, outputs 0;
  - issue a new start after clr returns high -> normal completion.
- Build without LINE_CLEAR_SCORE_EN and repeat the 4-row case -> lines = 4, score = 0, total_lines = 0.
